mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the datapath and data memory.
- Takes address, store data and funct3 from the decode/ALU stage and runs a req/ack handshake with data memory.
- Aligns store bytes and lanes, and extracts and extends load data.
- Its registered mem_int_out feeds the register-file write-data select.

Parameters:
ACK_TIMEOUT, 15, max cycles waiting in WAIT for dack before abort; 0 disables timeout.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request pulse, sampled in IDLE only
is_load  input  1  request is a load
is_store  input  1  request is a store
funct3  input  3  RV32I width/sign code
addr  input  32  byte address from ALU
store_data  input  32  rs2 value
busy  output  1  high in WAIT and DONE
done  output  1  one-cycle completion pulse
mem_int_out  output  32  extended load result, registered
timeout_err  output  1  sticky abort flag, cleared on next accepted start
misalign_err  output  1  misaligned access flag (see Optional Feature)
daddr  output  32  word address to dmem, {addr[31:2],2'b00}
dwdata  output  32  lane-replicated store data
dwe  output  4  byte write enables, 0 for loads
dreq  output  1  memory request, held until dack
drdata  input  32  memory read word
dack  input  1  memory acknowledge

Behaviour:
- Reset values (async):
  - State IDLE.
  - All outputs 0, including mem_int_out, daddr, dwdata, dwe, dreq, busy, done, timeout_err and misalign_err.
  - Timeout counter 0.
- Reset mid-operation: dreq drops immediately, state goes to IDLE, and any pending access is discarded.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - start=1 with exactly one of is_load/is_store: latch funct3 and addr[1:0]; register daddr, dwdata and dwe; set dreq=1 on the next edge; clear timeout_err; go to WAIT.
  - start with neither or both of is_load/is_store: ignored, no state change.
  - dack is ignored.
- Unsupported funct3:
  - Applies to loads with 011, 110 or 111, and to stores with funct3 ≥ 011.
  - No dreq; go directly to DONE; mem_int_out = 0; dwe = 0.
- WAIT:
  - dreq, daddr, dwdata and dwe are held stable.
  - Counter increments every WAIT cycle.
  - dack=1: for a load, capture the extracted drdata into mem_int_out. Then dreq=0 and go to DONE.
  - Counter reaches ACK_TIMEOUT without dack (ACK_TIMEOUT≠0): dreq=0, timeout_err=1, mem_int_out=0 (loads only), go to DONE.
  - If dack arrives in the same cycle the counter reaches ACK_TIMEOUT, dack wins.
- DONE: done=1 for exactly one cycle, then IDLE. start during WAIT or DONE is ignored.
- Latency: start at cycle N → dreq high at N+1. dack at cycle M → done at M+1. Minimum start-to-done is 2 cycles.
- mem_int_out holds its value until the next completing load; stores never change it.
- Load extraction, where off = addr[1:0]:
  - LB 000: sign-extended byte at off.
  - LH 001: sign-extended halfword at addr[1].
  - LW 010: full word.
  - LBU 100 and LHU 101: zero-extended byte/halfword.
- Store formatting:
  - SB: dwe = 4'b0001<<off, dwdata = {4{store_data[7:0]}}.
  - SH: dwe = addr[1] ? 1100 : 0011, dwdata = {2{store_data[15:0]}}.
  - SW: dwe = 1111, dwdata = store_data.
- Timeout counter width: $clog2(ACK_TIMEOUT+1), minimum 1 bit.

Optional Feature:
- Macro name: MISALIGN_TRAP_EN.
- Misaligned access definition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- Defined:
  - A misaligned access issues no dreq and goes straight to DONE.
  - misalign_err=1 for the same cycle as done.
  - mem_int_out is unchanged.
- Undefined:
  - misalign_err is tied 0.
  - Low address bits are truncated: halfword ops use only addr[1], word ops ignore addr[1:0].

Test Plan:
- Load LW: LW addr=0x100 with dack one cycle after dreq and drdata=0xDEADBEEF → daddr=0x100, dwe=0, done 3 cycles after start, mem_int_out=0xDEADBEEF.
- Load LB/LBU: drdata=0x80FF7F01 at addr=0x203 → LB gives mem_int_out=0xFFFFFF80; LBU gives 0x00000080.
- Store SH: SH addr=0x302, store_data=0x1234ABCD → dwe=1100, dwdata=0xABCDABCD, mem_int_out unchanged.
- Timeout: ACK_TIMEOUT=15 with dack never asserted → dreq drops after 15 WAIT cycles, done pulses, timeout_err=1, and timeout_err clears on the next accepted start.
- Reset mid-operation: reset asserted in WAIT → dreq=0 immediately and busy=0; a later dack is ignored; the next start works normally.
- Misaligned with MISALIGN_TRAP_EN defined: LW addr=0x101 → no dreq, done on the following cycle, misalign_err=1. With the macro undefined → access proceeds with daddr=0x100.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit between the datapath and data memory.
// It latches a request, runs a dreq/dack handshake with data memory, and places
// the extended load result in the registered mem_int_out.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned halfword
// and word accesses complete at once with misalign_err set. When it is undefined,
// the low address bits are dropped and misalign_err stays 0.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_int_out,
    output logic        timeout_err,
    output logic        misalign_err,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dwe,
    output logic        dreq,
    input  logic [31:0] drdata,
    input  logic        dack
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              load_q, load_d;
    logic [31:0]       daddr_q, daddr_d;
    logic [31:0]       dwdata_q, dwdata_d;
    logic [3:0]        dwe_q, dwe_d;
    logic              dreq_q, dreq_d;
    logic [31:0]       mem_q, mem_d;
    logic              tmo_q, tmo_d;
    logic              mis_q, mis_d;
    logic              misaligned_start;

    // Loads accept 000,001,010,100,101; stores accept 000,001,010.
    function automatic logic is_supported(input logic ld, input logic [2:0] f3);
        if (ld)
            return !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        else
            return (f3 < 3'b011);
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return off[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000:  return {4{sd[7:0]}};
            3'b001:  return {2{sd[15:0]}};
            3'b010:  return sd;
            default: return 32'h0;
        endcase
    endfunction

    // Halfwords use only off[1]; words ignore the offset entirely.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    assign misaligned_start = ((funct3[1:0] == 2'b01) && addr[0]) ||
                              ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misaligned_start = 1'b0;
`endif

    // State and datapath registers; a reset drops dreq at once and discards any pending access.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of every other register.
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            load_q   <= 1'b0;
            daddr_q  <= 32'h0;
            dwdata_q <= 32'h0;
            dwe_q    <= 4'h0;
            dreq_q   <= 1'b0;
            mem_q    <= 32'h0;
            tmo_q    <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            load_q   <= load_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            dwe_q    <= dwe_d;
            dreq_q   <= dreq_d;
            mem_q    <= mem_d;
            tmo_q    <= tmo_d;
            mis_q    <= mis_d;
        end
    end

    // Next-state and datapath update for the IDLE -> WAIT -> DONE handshake.
    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no
        // path through the case statement can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        load_d   = load_q;
        daddr_d  = daddr_q;
        dwdata_d = dwdata_q;
        dwe_d    = dwe_q;
        dreq_d   = dreq_q;
        mem_d    = mem_q;
        tmo_d    = tmo_q;
        mis_d    = mis_q;

        case (state_q)
            S_IDLE: begin
                if (start && (is_load ^ is_store)) begin
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    load_d   = is_load;
                    daddr_d  = {addr[31:2], 2'b00};
                    cnt_d    = '0;
                    tmo_d    = 1'b0;
                    mis_d    = 1'b0;
                    if (!is_supported(is_load, funct3)) begin
                        dwe_d    = 4'h0;
                        dwdata_d = 32'h0;
                        if (is_load)
                            mem_d = 32'h0;
                        state_d = S_DONE;
                    end else if (misaligned_start) begin
                        dwe_d    = 4'h0;
                        dwdata_d = 32'h0;
                        mis_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        dwe_d    = is_store ? store_lanes(funct3, addr[1:0]) : 4'h0;
                        dwdata_d = is_store ? store_fmt(funct3, store_data) : 32'h0;
                        dreq_d   = 1'b1;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dack) begin
                    if (load_q)
                        mem_d = load_extract(funct3_q, off_q, drdata);
                    dreq_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((ACK_TIMEOUT != 0) && (cnt_d == CNT_W'(ACK_TIMEOUT))) begin
                        dreq_d = 1'b0;
                        tmo_d  = 1'b1;
                        if (load_q)
                            mem_d = 32'h0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign mem_int_out  = mem_q;
    assign timeout_err  = tmo_q;
    assign daddr        = daddr_q;
    assign dwdata       = dwdata_q;
    assign dwe          = dwe_q;
    assign dreq         = dreq_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (default ACK_TIMEOUT = 15).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, timeout_err, misalign_err, dreq, dack;
    logic [31:0] mem_int_out, daddr, dwdata, drdata;
    logic [3:0]  dwe;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .mem_int_out(mem_int_out), .timeout_err(timeout_err), .misalign_err(misalign_err),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .dreq(dreq), .drdata(drdata), .dack(dack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          dly;
        logic        nodreq;
        logic [31:0] exp_mem;
        logic [31:0] exp_daddr;
        logic [3:0]  exp_dwe;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %b expected %b", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic clear_inputs();
        start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    endtask

    // One access: drive start, answer dack after dly cycles of dreq, compare at done.
    task automatic run_access(input string tag, input vec_t v);
        logic [31:0] exp_m;
        @(posedge clk); #1;
        start = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
        addr = v.addr; store_data = v.sdata;
        exp_q.push_back(v.exp_mem);
        @(posedge clk); #1;
        clear_inputs();
        check1({tag, " tmo_clear"}, timeout_err, 1'b0);
        if (!v.nodreq) begin
            check1({tag, " dreq"}, dreq, 1'b1);
            check1({tag, " busy"}, busy, 1'b1);
            check1({tag, " early_done"}, done, 1'b0);
            check({tag, " daddr"}, daddr, v.exp_daddr);
            check({tag, " dwe"}, {28'h0, dwe}, {28'h0, v.exp_dwe});
            if (v.st)
                check({tag, " dwdata"}, dwdata, v.exp_wdata);
            for (int i = 0; i < v.dly; i++) begin
                @(posedge clk); #1;
                check1({tag, " wait_done"}, done, 1'b0);
                check1({tag, " dreq_held"}, dreq, 1'b1);
            end
            dack = 1'b1; drdata = v.rdata;
            @(posedge clk); #1;
            dack = 1'b0; drdata = 32'h0;
            check1({tag, " dreq_drop"}, dreq, 1'b0);
        end else begin
            check1({tag, " no_dreq"}, dreq, 1'b0);
            check({tag, " dwe_zero"}, {28'h0, dwe}, 32'h0);
        end
        check1({tag, " done"}, done, 1'b1);
        check1({tag, " misalign"}, misalign_err, v.exp_mis);
        exp_m = exp_q.pop_front();
        check({tag, " mem_int_out"}, mem_int_out, exp_m);
        @(posedge clk); #1;
        check1({tag, " done_pulse"}, done, 1'b0);
        check1({tag, " idle"}, busy, 1'b0);
    endtask

    initial begin
        int n;
        vec_t mv;

        //          ld    st    f3      addr           sdata          rdata         dly nodreq exp_mem        daddr          dwe      wdata          mis
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 32'h0000_0100, 4'b0000, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h80FF7F01, 0, 1'b0, 32'hFFFFFF80, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h80FF7F01, 2, 1'b0, 32'h00000080, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0302, 32'h1234ABCD, 32'h0,         1, 1'b0, 32'h00000080, 32'h0000_0300, 4'b1100, 32'hABCDABCD, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h80FF7F01, 0, 1'b0, 32'hFFFF80FF, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0,         32'h80FF7F01, 1, 1'b0, 32'h00007F01, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0,         32'h80FF7F01, 2, 1'b0, 32'h0000007F, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h000000A5, 32'h0,         0, 1'b0, 32'h0000007F, 32'h0000_0100, 4'b0010, 32'hA5A5A5A5, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFEF00D, 32'h0,         3, 1'b0, 32'h0000007F, 32'h0000_0040, 4'b1111, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0202, 32'h0,         32'h80FF7F01, 1, 1'b0, 32'hFFFFFFFF, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0,         32'h80FF7F01, 0, 1'b0, 32'h000080FF, 32'h0000_0200, 4'b0000, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         0, 1'b1, 32'h00000000, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'b011, 32'h0000_0014, 32'h11223344, 32'h0,         0, 1'b1, 32'h00000000, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0,         32'h12345678, 2, 1'b0, 32'h12345678, 32'h0000_0008, 4'b0000, 32'h0,         1'b0};

        clear_inputs();
        dack = 1'b0; drdata = 32'h0;
        reset = 1'b1;
        #2;
        check1("rst busy", busy, 1'b0);
        check1("rst done", done, 1'b0);
        check1("rst dreq", dreq, 1'b0);
        check("rst mem_int_out", mem_int_out, 32'h0);
        check("rst daddr", daddr, 32'h0);
        check("rst dwdata", dwdata, 32'h0);
        check("rst dwe", {28'h0, dwe}, 32'h0);
        check1("rst timeout_err", timeout_err, 1'b0);
        check1("rst misalign_err", misalign_err, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Starts with neither or both access kinds are ignored.
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h100;
        @(posedge clk); #1;
        check1("both ignored busy", busy, 1'b0);
        check1("both ignored dreq", dreq, 1'b0);
        is_load = 1'b0; is_store = 1'b0;
        @(posedge clk); #1;
        check1("neither ignored busy", busy, 1'b0);
        clear_inputs();

        for (int i = 0; i < 14; i++)
            run_access($sformatf("vec%0d", i), vecs[i]);

        // Timeout: dack never comes.
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        clear_inputs();
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (dreq) n++;
            @(posedge clk); #1;
        end
        check("tmo dreq_cycles", 32'(n), 32'd15);
        check1("tmo done", done, 1'b1);
        check1("tmo dreq", dreq, 1'b0);
        check1("tmo err", timeout_err, 1'b1);
        check("tmo mem_int_out", mem_int_out, 32'h0);
        @(posedge clk); #1;
        check1("tmo sticky", timeout_err, 1'b1);
        run_access("after_tmo", vecs[5]);

        // Reset in WAIT: dreq drops at once, a later dack is ignored.
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h600;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        check1("mid dreq_before", dreq, 1'b1);
        reset = 1'b1;
        #1;
        check1("mid dreq", dreq, 1'b0);
        check1("mid busy", busy, 1'b0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        dack = 1'b1; drdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dack = 1'b0;
        check1("mid late_dack done", done, 1'b0);
        check1("mid late_dack busy", busy, 1'b0);
        check("mid mem_int_out", mem_int_out, 32'h0);
        run_access("after_rst", vecs[0]);

        // Misaligned LW at 0x101.
`ifdef MISALIGN_TRAP_EN
        mv = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h55AA55AA, 0, 1'b1,
               32'hDEADBEEF, 32'h0, 4'b0000, 32'h0, 1'b1};
`else
        mv = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h55AA55AA, 0, 1'b0,
               32'h55AA55AA, 32'h100, 4'b0000, 32'h0, 1'b0};
`endif
        run_access("misalign", mv);

        // A start pulse during WAIT must not launch a second access.
        @(posedge clk); #1;
        start = 1'b1; is_load = 1'b1; funct3 = 3'b000; addr = 32'h700;
        @(posedge clk); #1;
        is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h800; store_data = 32'hFFFF0000;
        @(posedge clk); #1;
        clear_inputs();
        check("busy_start daddr", daddr, 32'h700);
        check("busy_start dwe", {28'h0, dwe}, 32'h0);
        dack = 1'b1; drdata = 32'h0000_0081;
        @(posedge clk); #1;
        dack = 1'b0;
        check1("busy_start done", done, 1'b1);
        check("busy_start mem", mem_int_out, 32'hFFFFFF81);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check1("busy_start idle", busy, 1'b0);
        check1("busy_start no_dreq", dreq, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
